// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types for the two-client main-memory arbiter.
//   arb_state_t  : arbiter FSM states (IDLE, OWN_I, OWN_D)
//   client_t     : identifies the instruction or data cache
//   line_t       : one cache line at the default line size (8 x 32-bit words)
//   other_client : returns the opposite client, used for round-robin rotation
package mem_arb_pkg;

    localparam int WORD_W            = 32;
    localparam int DEF_LINE_ADDR_LEN = 3;
    localparam int DEF_LINE_SIZE     = 1 << DEF_LINE_ADDR_LEN;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        CLI_I = 1'b0,
        CLI_D = 1'b1
    } client_t;

    // Word k of the line lives in bits [k*32 +: 32], matching the flat
    // line ports of the arbiter and caches.
    typedef logic [DEF_LINE_SIZE-1:0][WORD_W-1:0] line_t;

    function automatic client_t other_client(input client_t c);
        return (c == CLI_I) ? CLI_D : CLI_I;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2
// Combinational two-input round-robin picker.
//   req_i, req_d : requests from the I-cache and D-cache clients
//   prio         : client preferred when both request
//   valid        : at least one client requests
//   sel          : selected client (meaningful only when valid)
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic    req_i,
    input  logic    req_d,
    input  client_t prio,
    output logic    valid,
    output client_t sel
);

    always_comb begin
        valid = req_i | req_d;
        sel   = CLI_I;
        if (req_i && req_d) begin
            sel = prio;
        end else if (req_d) begin
            sel = CLI_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single line-granular main-memory port between the I-cache and
// the D-cache with round-robin priority, and counts completed transactions
// per client with saturating counters.
//   clk, rst_n                         : clock, asynchronous active-low reset
//   i_rd_req/i_wr_req/i_addr/i_wr_line : I-cache memory-side request
//   i_gnt                              : grant pulse to the I-cache
//   d_rd_req/d_wr_req/d_addr/d_wr_line : D-cache memory-side request
//   d_gnt                              : grant pulse to the D-cache
//   rd_line                            : memory read line, broadcast to both
//   mem_rd_req/mem_wr_req/mem_addr/mem_wr_line : forwarded to main memory
//   mem_gnt, mem_rd_line               : main-memory grant and read line
//   i_cnt, d_cnt                       : completed transactions, saturating
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int LINE_ADDR_LEN = 3,
    parameter  int ADDR_LEN      = 9,
    parameter  int CNT_W         = 16,
    localparam int LINE_SIZE     = 1 << LINE_ADDR_LEN,
    localparam int LINE_W        = 32 * LINE_SIZE
)
(
    input  logic                clk,
    input  logic                rst_n,

    input  logic                i_rd_req,
    input  logic                i_wr_req,
    input  logic [ADDR_LEN-1:0] i_addr,
    input  logic [LINE_W-1:0]   i_wr_line,
    output logic                i_gnt,

    input  logic                d_rd_req,
    input  logic                d_wr_req,
    input  logic [ADDR_LEN-1:0] d_addr,
    input  logic [LINE_W-1:0]   d_wr_line,
    output logic                d_gnt,

    output logic [LINE_W-1:0]   rd_line,

    output logic                mem_rd_req,
    output logic                mem_wr_req,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [LINE_W-1:0]   mem_wr_line,
    input  logic                mem_gnt,
    input  logic [LINE_W-1:0]   mem_rd_line,

    output logic [CNT_W-1:0]    i_cnt,
    output logic [CNT_W-1:0]    d_cnt
);

    arb_state_t state;
    arb_state_t state_next;
    client_t    prio;
    logic       i_req;
    logic       d_req;
    logic       pick_valid;
    client_t    pick_sel;

    assign i_req = i_rd_req | i_wr_req;
    assign d_req = d_rd_req | d_wr_req;

    // Memory holds the read line after its grant, so a plain pass-through
    // is enough for the owner to capture it.
    assign rd_line = mem_rd_line;

    rr_pick2 u_pick (
        .req_i (i_req),
        .req_d (d_req),
        .prio  (prio),
        .valid (pick_valid),
        .sel   (pick_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The owner's request is forwarded combinationally so an abort (owner
    // drops its request) removes the memory request in the same cycle.
    // A write wins over a read when a client asserts both. A grant seen in
    // IDLE is ignored because nothing decodes mem_gnt there.
    always_comb begin
        state_next  = state;
        i_gnt       = 1'b0;
        d_gnt       = 1'b0;
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        mem_addr    = '0;
        mem_wr_line = '0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = (pick_sel == CLI_I) ? OWN_I : OWN_D;
                end
            end
            OWN_I: begin
                mem_addr    = i_addr;
                mem_wr_line = i_wr_line;
                mem_wr_req  = i_wr_req;
                mem_rd_req  = i_rd_req & ~i_wr_req;
                i_gnt       = mem_gnt;
                if (mem_gnt || !i_req) begin
                    state_next = IDLE;
                end
            end
            OWN_D: begin
                mem_addr    = d_addr;
                mem_wr_line = d_wr_line;
                mem_wr_req  = d_wr_req;
                mem_rd_req  = d_rd_req & ~d_wr_req;
                d_gnt       = mem_gnt;
                if (mem_gnt || !d_req) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Priority rotates only on a completed transaction; aborts leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= CLI_I;
        end else if (i_gnt) begin
            prio <= other_client(CLI_I);
        end else if (d_gnt) begin
            prio <= other_client(CLI_D);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_cnt <= '0;
            d_cnt <= '0;
        end else begin
            if (i_gnt && (i_cnt != '1)) begin
                i_cnt <= i_cnt + CNT_W'(1);
            end
            if (d_gnt && (d_cnt != '1)) begin
                d_cnt <= d_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with a main-memory stub of configurable
// grant latency. A second instance with CNT_W=2 receives identical inputs
// and is used for counter saturation.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int LA  = 3;
    localparam int AL  = 9;
    localparam int LW  = 32 * (1 << LA);

    logic          clk;
    logic          rst_n;
    logic          i_rd_req, i_wr_req, d_rd_req, d_wr_req;
    logic [AL-1:0] i_addr, d_addr;
    logic [LW-1:0] i_wr_line, d_wr_line;
    logic          i_gnt, d_gnt;
    logic [LW-1:0] rd_line;
    logic          mem_rd_req, mem_wr_req;
    logic [AL-1:0] mem_addr;
    logic [LW-1:0] mem_wr_line;
    logic          mem_gnt;
    logic [LW-1:0] mem_rd_line;
    logic [15:0]   i_cnt, d_cnt;

    logic          sat_i_gnt, sat_d_gnt, sat_mem_rd_req, sat_mem_wr_req;
    logic [AL-1:0] sat_mem_addr;
    logic [LW-1:0] sat_rd_line, sat_mem_wr_line;
    logic [1:0]    sat_i_cnt, sat_d_cnt;

    logic          stub_gnt;
    logic          late_gnt;
    int            mem_lat;
    int            stub_cnt;
    int            checks;
    int            errors;

    assign mem_gnt = stub_gnt | late_gnt;

    mem_arbiter #(.LINE_ADDR_LEN(LA), .ADDR_LEN(AL), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_rd_req(i_rd_req), .i_wr_req(i_wr_req), .i_addr(i_addr),
        .i_wr_line(i_wr_line), .i_gnt(i_gnt),
        .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr),
        .d_wr_line(d_wr_line), .d_gnt(d_gnt),
        .rd_line(rd_line),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wr_line(mem_wr_line), .mem_gnt(mem_gnt), .mem_rd_line(mem_rd_line),
        .i_cnt(i_cnt), .d_cnt(d_cnt)
    );

    mem_arbiter #(.LINE_ADDR_LEN(LA), .ADDR_LEN(AL), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .i_rd_req(i_rd_req), .i_wr_req(i_wr_req), .i_addr(i_addr),
        .i_wr_line(i_wr_line), .i_gnt(sat_i_gnt),
        .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr),
        .d_wr_line(d_wr_line), .d_gnt(sat_d_gnt),
        .rd_line(sat_rd_line),
        .mem_rd_req(sat_mem_rd_req), .mem_wr_req(sat_mem_wr_req),
        .mem_addr(sat_mem_addr), .mem_wr_line(sat_mem_wr_line),
        .mem_gnt(mem_gnt), .mem_rd_line(mem_rd_line),
        .i_cnt(sat_i_cnt), .d_cnt(sat_d_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory stub: acts 3 time units after each rising edge. It raises its
    // grant once a request has been seen for mem_lat consecutive cycles,
    // holds it for one cycle and presents a read line derived from the address.
    initial begin
        stub_gnt    = 1'b0;
        stub_cnt    = 0;
        mem_rd_line = '0;
        forever begin
            @(posedge clk);
            #3;
            if (!rst_n) begin
                stub_gnt = 1'b0;
                stub_cnt = 0;
            end else if (stub_gnt) begin
                stub_gnt = 1'b0;
                stub_cnt = 0;
            end else if (mem_rd_req || mem_wr_req) begin
                stub_cnt++;
                if (stub_cnt >= mem_lat) begin
                    stub_gnt = 1'b1;
                    for (int k = 0; k < 8; k++) begin
                        mem_rd_line[k*32 +: 32] = 32'hA000_0000 + (32'(mem_addr) << 4) + 32'(k);
                    end
                end
            end else begin
                stub_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_inputs();
        i_rd_req  = 1'b0;
        i_wr_req  = 1'b0;
        d_rd_req  = 1'b0;
        d_wr_req  = 1'b0;
        i_addr    = '0;
        d_addr    = '0;
        i_wr_line = '0;
        d_wr_line = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits (sampling on falling edges) until either client grant is seen.
    task automatic wait_gnt(input int max_cycles, output int n,
                            output logic gi, output logic gd);
        n  = 0;
        gi = 1'b0;
        gd = 1'b0;
        while (n < max_cycles && !gi && !gd) begin
            @(negedge clk);
            n++;
            gi = i_gnt;
            gd = d_gnt;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt, mem_rd_req, mem_wr_req} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_held_reqs: got %b expected 0000", {i_gnt, d_gnt, mem_rd_req, mem_wr_req});
        end
        checks++;
        if (mem_addr !== 9'h000 || i_cnt !== 16'd0 || d_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_held_addr_cnt: got addr=%h i=%0d d=%0d expected 0/0/0", mem_addr, i_cnt, d_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt, mem_rd_req, mem_wr_req} !== 4'b0000 || mem_addr !== 9'h000) begin
            errors++;
            $display("[TB] FAIL reset_after: got %b addr=%h expected 0000 addr=0", {i_gnt, d_gnt, mem_rd_req, mem_wr_req}, mem_addr);
        end
    endtask

    task automatic test_single_read();
        int   n;
        logic gi, gd;
        mem_lat  = 4;
        i_addr   = 9'h005;
        i_rd_req = 1'b1;
        #1;
        checks++;
        if (mem_rd_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_latency: mem_rd_req got %b expected 0 before edge", mem_rd_req);
        end
        @(posedge clk);
        #1;
        checks++;
        if (mem_rd_req !== 1'b1 || mem_wr_req !== 1'b0 || mem_addr !== 9'h005) begin
            errors++;
            $display("[TB] FAIL single_forward: got rd=%b wr=%b addr=%h expected 1/0/005", mem_rd_req, mem_wr_req, mem_addr);
        end
        wait_gnt(20, n, gi, gd);
        checks++;
        if (gi !== 1'b1 || gd !== 1'b0 || n !== 4) begin
            errors++;
            $display("[TB] FAIL single_grant: got i_gnt=%b d_gnt=%b cycles=%0d expected 1/0/4", gi, gd, n);
        end
        checks++;
        if (rd_line[31:0] !== 32'hA000_0050) begin
            errors++;
            $display("[TB] FAIL single_rd_line: got %h expected a0000050", rd_line[31:0]);
        end
        i_rd_req = 1'b0;
        i_addr   = '0;
        @(negedge clk);
        checks++;
        if (i_cnt !== 16'd1 || d_cnt !== 16'd0 || mem_rd_req !== 1'b0 || i_gnt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_done: got i=%0d d=%0d rd=%b gnt=%b expected 1/0/0/0", i_cnt, d_cnt, mem_rd_req, i_gnt);
        end
    endtask

    task automatic test_simultaneous();
        int   n;
        logic gi, gd;
        do_reset();
        mem_lat  = 4;
        i_addr   = 9'h003;
        i_rd_req = 1'b1;
        d_addr   = 9'h01A;
        d_wr_req = 1'b1;
        for (int k = 0; k < 8; k++) d_wr_line[k*32 +: 32] = 32'h100 + 32'(k);
        @(posedge clk);
        #1;
        checks++;
        if (mem_addr !== 9'h003 || mem_rd_req !== 1'b1 || mem_wr_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sim_first_owner: got addr=%h rd=%b wr=%b expected 003/1/0", mem_addr, mem_rd_req, mem_wr_req);
        end
        wait_gnt(20, n, gi, gd);
        checks++;
        if ({gi, gd} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL sim_first_grant: got {i,d}=%b expected 10", {gi, gd});
        end
        i_rd_req = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (mem_wr_req !== 1'b0 || mem_addr !== 9'h000) begin
            errors++;
            $display("[TB] FAIL sim_idle_gap: got wr=%b addr=%h expected 0/000", mem_wr_req, mem_addr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (mem_wr_req !== 1'b1 || mem_rd_req !== 1'b0 || mem_addr !== 9'h01A || mem_wr_line[3*32 +: 32] !== 32'h103) begin
            errors++;
            $display("[TB] FAIL sim_second_owner: got wr=%b rd=%b addr=%h word3=%h expected 1/0/01a/103",
                     mem_wr_req, mem_rd_req, mem_addr, mem_wr_line[3*32 +: 32]);
        end
        wait_gnt(20, n, gi, gd);
        checks++;
        if ({gi, gd} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL sim_second_grant: got {i,d}=%b expected 01", {gi, gd});
        end
        d_wr_req = 1'b0;
        @(negedge clk);
        checks++;
        if (i_cnt !== 16'd1 || d_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL sim_counts: got i=%0d d=%0d expected 1/1", i_cnt, d_cnt);
        end
        i_rd_req = 1'b1;
        d_rd_req = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (mem_addr !== 9'h003) begin
            errors++;
            $display("[TB] FAIL sim_prio_back_to_i: got addr=%h expected 003", mem_addr);
        end
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int   n;
        logic gi, gd;
        logic [1:0] want;
        do_reset();
        mem_lat  = 3;
        i_addr   = 9'h004;
        d_addr   = 9'h008;
        i_rd_req = 1'b1;
        d_rd_req = 1'b1;
        for (int t = 0; t < 4; t++) begin
            want = (t % 2 == 0) ? 2'b10 : 2'b01;
            wait_gnt(30, n, gi, gd);
            checks++;
            if ({gi, gd} !== want) begin
                errors++;
                $display("[TB] FAIL fair_order_%0d: got {i,d}=%b expected %b", t, {gi, gd}, want);
            end
        end
        i_rd_req = 1'b0;
        d_rd_req = 1'b0;
        @(negedge clk);
        checks++;
        if (i_cnt !== 16'd2 || d_cnt !== 16'd2) begin
            errors++;
            $display("[TB] FAIL fair_counts: got i=%0d d=%0d expected 2/2", i_cnt, d_cnt);
        end
    endtask

    task automatic test_rd_wr_both();
        int   n;
        logic gi, gd;
        mem_lat  = 3;
        d_addr   = 9'h007;
        d_rd_req = 1'b1;
        d_wr_req = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (mem_wr_req !== 1'b1 || mem_rd_req !== 1'b0 || mem_addr !== 9'h007) begin
            errors++;
            $display("[TB] FAIL rdwr_forward: got wr=%b rd=%b addr=%h expected 1/0/007", mem_wr_req, mem_rd_req, mem_addr);
        end
        wait_gnt(20, n, gi, gd);
        checks++;
        if ({gi, gd} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rdwr_grant: got {i,d}=%b expected 01", {gi, gd});
        end
        d_rd_req = 1'b0;
        d_wr_req = 1'b0;
        @(negedge clk);
        checks++;
        if (d_cnt !== 16'd3) begin
            errors++;
            $display("[TB] FAIL rdwr_count: got d=%0d expected 3", d_cnt);
        end
    endtask

    task automatic test_abort();
        int   n;
        logic gi, gd;
        mem_lat  = 6;
        d_addr   = 9'h011;
        d_rd_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        d_rd_req = 1'b0;
        #1;
        checks++;
        if (mem_rd_req !== 1'b0 || mem_addr !== 9'h011) begin
            errors++;
            $display("[TB] FAIL abort_drop: got rd=%b addr=%h expected 0/011", mem_rd_req, mem_addr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (mem_addr !== 9'h000) begin
            errors++;
            $display("[TB] FAIL abort_idle: got addr=%h expected 000", mem_addr);
        end
        wait_gnt(8, n, gi, gd);
        checks++;
        if ({gi, gd} !== 2'b00 || d_cnt !== 16'd3) begin
            errors++;
            $display("[TB] FAIL abort_no_grant: got {i,d}=%b d=%0d expected 00/3", {gi, gd}, d_cnt);
        end
        i_addr   = 9'h002;
        i_rd_req = 1'b1;
        d_rd_req = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (mem_addr !== 9'h002) begin
            errors++;
            $display("[TB] FAIL abort_prio_kept: got addr=%h expected 002", mem_addr);
        end
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_late_grant();
        late_gnt = 1'b1;
        #1;
        checks++;
        if (i_gnt !== 1'b0 || d_gnt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL late_grant_pulse: got i=%b d=%b expected 0/0", i_gnt, d_gnt);
        end
        @(negedge clk);
        late_gnt = 1'b0;
        checks++;
        if (i_cnt !== 16'd2 || d_cnt !== 16'd3 || mem_rd_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL late_grant_counts: got i=%0d d=%0d rd=%b expected 2/3/0", i_cnt, d_cnt, mem_rd_req);
        end
    endtask

    task automatic test_reset_mid();
        mem_lat  = 6;
        i_addr   = 9'h009;
        i_rd_req = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (mem_rd_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_owning: got rd=%b expected 1", mem_rd_req);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({i_gnt, d_gnt, mem_rd_req, mem_wr_req} !== 4'b0000 || mem_addr !== 9'h000) begin
            errors++;
            $display("[TB] FAIL rstmid_outputs: got %b addr=%h expected 0000/000", {i_gnt, d_gnt, mem_rd_req, mem_wr_req}, mem_addr);
        end
        checks++;
        if (i_cnt !== 16'd0 || d_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL rstmid_counts: got i=%0d d=%0d expected 0/0", i_cnt, d_cnt);
        end
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int   n;
        logic gi, gd;
        mem_lat = 2;
        i_addr  = 9'h001;
        for (int t = 0; t < 5; t++) begin
            i_rd_req = 1'b1;
            wait_gnt(20, n, gi, gd);
            checks++;
            if (gi !== 1'b1) begin
                errors++;
                $display("[TB] FAIL sat_grant_%0d: got i_gnt=%b expected 1", t, gi);
            end
            i_rd_req = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (sat_i_cnt !== 2'd3 || sat_d_cnt !== 2'd0) begin
            errors++;
            $display("[TB] FAIL sat_counter: got i=%0d d=%0d expected 3/0", sat_i_cnt, sat_d_cnt);
        end
        checks++;
        if (i_cnt !== 16'd5) begin
            errors++;
            $display("[TB] FAIL sat_wide_counter: got i=%0d expected 5", i_cnt);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        mem_lat  = 4;
        late_gnt = 1'b0;
        rst_n    = 1'b0;
        clear_inputs();
        $display("[TB] starting mem_arbiter bench");
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fairness();
        test_rd_wr_both();
        test_abort();
        test_late_grant();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-client arbiter that shares the single line-granular main-memory port between the instruction cache and the data cache. Each cache presents its usual memory-side interface: line read/write request, line address, write line, grant. The arbiter picks one owner with round-robin priority, forwards that owner's request to memory until the memory grant, and routes the grant back. It sits between the two cache instances and one `main_mem` instance, and keeps per-client saturating transaction counters for performance analysis.

## Interface
Parameters:
- `LINE_ADDR_LEN`, default 3: log2 of words per line; `LINE_SIZE = 1 << LINE_ADDR_LEN`.
- `ADDR_LEN`, default 9: line-address width, equal to TAG+SET bits of the caches.
- `CNT_W`, default 16: width of the transaction counters.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `i_rd_req`, `i_wr_req`  in  1 each: I-cache line read / write request.
- `i_addr`  in  ADDR_LEN: I-cache line address.
- `i_wr_line`  in  32 x LINE_SIZE: I-cache write data.
- `i_gnt`  out  1: grant pulse to the I-cache.
- `d_rd_req`, `d_wr_req`, `d_addr`, `d_wr_line`, `d_gnt`: same as the I-side, for the D-cache.
- `rd_line`  out  32 x LINE_SIZE: memory read line, broadcast to both clients.
- `mem_rd_req`, `mem_wr_req`  out  1 each: to main memory.
- `mem_addr`  out  ADDR_LEN: to main memory.
- `mem_wr_line`  out  32 x LINE_SIZE: to main memory.
- `mem_gnt`  in  1: main-memory grant, a one-cycle pulse.
- `mem_rd_line`  in  32 x LINE_SIZE: main-memory read line.
- `i_cnt`, `d_cnt`  out  CNT_W each: number of completed transactions per client, saturating.

## Operation
- **States:** `IDLE`, `OWN_I`, `OWN_D`.
- **Round-robin pointer:** `prio` (0 = I preferred). Reset value 0.
- **In `IDLE`:**
  - Client request = `rd_req | wr_req`.
  - If only one client requests, go to that client's `OWN_x` state.
  - If both request, grant the client indicated by `prio`.
  - If neither requests, stay in `IDLE`.
  - In `IDLE` all `mem_*` request outputs are 0, `mem_addr` is 0 and `mem_wr_line` is all-zero.
- **In `OWN_x`:**
  - `mem_addr` and `mem_wr_line` are taken combinationally from client x.
  - `mem_wr_req = x_wr_req`.
  - `mem_rd_req = x_rd_req & ~x_wr_req`: write wins if a client asserts both.
  - The non-owner's requests are ignored, and its grant stays 0.
- **Grant:**
  - `x_gnt = mem_gnt` while in `OWN_x`; 0 in every other case.
  - On `mem_gnt`: go to `IDLE`, set `prio` to the other client, and increment `x_cnt` unless it is all-ones.
- **Abort:** if the owner drops both requests before `mem_gnt`, go to `IDLE`. `prio` and the counter are unchanged. `mem_*` requests drop in that same cycle, because they are combinational from the owner.
- **`rd_line`:** equals `mem_rd_line`, passed through combinationally. It is valid to the owner in the `mem_gnt` cycle and the cycles after, as `main_mem` holds it.
- **Client obligation:** hold the request, address and write line stable from assertion until its grant. The arbiter does not latch them.

## Timing
- **Reset values:** state `IDLE`, `prio` 0, `i_cnt` and `d_cnt` 0. All request and grant outputs are 0 and `mem_addr` is 0 while reset is held and immediately after.
- **Arbitration latency:** 1 cycle. A request seen in `IDLE` at edge k is forwarded to memory during cycle k+1.
- **Transaction length:** for memory grant latency L, the client's grant arrives L cycles after forwarding starts. The arbiter returns to `IDLE` at the following edge.
- **Back-to-back transactions:** a client re-requesting immediately (e.g., SWAP_OUT then SWAP_IN) passes through one `IDLE` cycle. If the other client is waiting, the other client wins.
- **Simultaneous first requests:** both clients requesting in the same `IDLE` cycle resolve by `prio`. No starvation: the longest wait is one foreign transaction.
- **Reset during a transaction:** asynchronous return to `IDLE`. Memory requests drop with no grant forwarded, and the counters clear.
- **Late grant:** a `mem_gnt` arriving in `IDLE` (memory-model error) is ignored. No client grant is produced and no counter changes.

## Structure
- **Package `mem_arb_pkg`:**
  - `arb_state_t` enum (`IDLE`, `OWN_I`, `OWN_D`).
  - `client_t` enum (`CLI_I`, `CLI_D`).
  - Line array typedef parameterised by `LINE_SIZE`.
- **Sub-module `rr_pick2`:** combinational two-input round-robin picker. Inputs are two requests and `prio`; outputs are a valid flag and the selected client.
- **Top:** state register, `prio` register, counters and the output muxes.

## Test plan
- **Single I read:** stub memory L=4, `i_rd_req` with addr 0x05. `mem_rd_req` rises 1 cycle later with `mem_addr`=0x05. `i_gnt` pulses at cycle 5, `d_gnt` stays 0, `i_cnt`=1, then back to `IDLE`.
- **Simultaneous requests:** `i_rd_req` and `d_wr_req` (addr 0x1A, line words 0..7 = 0x100+k) in the same cycle after reset. I is served first. D is served next, with `mem_wr_line` word 3 = 0x103. `prio` ends at 0.
- **Fairness:** I re-requests continuously while D holds a request. Grants alternate I, D, I, D, and counters read 2/2 after 4 transactions.
- **Both rd and wr from D:** only `mem_wr_req`=1 is forwarded; `mem_rd_req`=0.
- **Abort:** D drops its request 2 cycles into ownership (L=6). The arbiter returns to `IDLE` the next cycle, no `d_gnt` is produced and `d_cnt` is unchanged.
- **Reset mid-transaction and saturation:** assert `rst_n`=0 in `OWN_I`. All outputs read 0 asynchronously and the counters clear. Separately, with `CNT_W`=2, run 5 I transactions: `i_cnt` stays at 3.
